// File: rtl/video_timing_gen.sv
// Raster timing generator: sync, data-enable, pixel coordinates
// and an early line-fetch request for the line buffer.
module video_timing_gen #(
  parameter int   H_ACTIVE  = 1024,
  parameter int   H_FP      = 24,
  parameter int   H_SYNC    = 136,
  parameter int   H_BP      = 160,
  parameter int   V_ACTIVE  = 768,
  parameter int   V_FP      = 3,
  parameter int   V_SYNC    = 6,
  parameter int   V_BP      = 29,
  parameter logic HSYNC_POL = 1'b0,
  parameter logic VSYNC_POL = 1'b0,
  parameter int   PREFETCH  = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic        LINE_REQ,
  output logic [9:0]  LINE_REQ_Y
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (PREFETCH < 1 || PREFETCH > H_FP + H_SYNC + H_BP ||
        H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_bad_params
      $error("video_timing_gen: illegal timing parameters");
    end
  endgenerate

  localparam logic [10:0] X_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] X_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] X_REQ  = 11'(H_TOTAL - PREFETCH);
  localparam logic [9:0]  Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0]  Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic        run_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d, y_nxt;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic        lr_q, lr_d;
  logic [9:0]  lry_q, lry_d;

  always_comb begin
    state_d = state_q;
    x_d     = '0;
    y_d     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (ENABLE) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!ENABLE) begin
          state_d = ST_IDLE;
        end else if (x_q == X_LAST) begin
          y_d = (y_q == Y_LAST) ? '0 : y_q + 10'd1;
        end else begin
          x_d = x_q + 11'd1;
          y_d = y_q;
        end
      end
    endcase
  end

  // Outputs are decoded from the next position so they line up with X/Y.
  always_comb begin
    run_d   = (state_d == ST_RUN);
    y_nxt   = (y_d == Y_LAST) ? '0 : y_d + 10'd1;
    hsync_d = (run_d && x_d >= HS_BEG && x_d <= HS_END) ?
              HSYNC_POL : ~HSYNC_POL;
    vsync_d = (run_d && y_d >= VS_BEG && y_d <= VS_END) ?
              VSYNC_POL : ~VSYNC_POL;
    de_d    = run_d && (x_d < X_ACT) && (y_d < Y_ACT);
    ls_d    = run_d && (x_d == '0);
    fs_d    = ls_d && (y_d == '0);
    lr_d    = run_d && (x_d == X_REQ) && (y_nxt < Y_ACT);
    lry_d   = lry_q;
    if (!run_d)    lry_d = '0;
    else if (lr_d) lry_d = y_nxt;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      de_q    <= 1'b0;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      lr_q    <= 1'b0;
      lry_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      lr_q    <= lr_d;
      lry_q   <= lry_d;
    end
  end

  assign X           = x_q;
  assign Y           = y_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign LINE_START  = ls_q;
  assign FRAME_START = fs_q;
  assign LINE_REQ    = lr_q;
  assign LINE_REQ_Y  = lry_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen on a shrunken 32x20 raster
// (16 active px, sync X 20..25, 12 active lines, vsync Y 14..16).
module tb_video_timing_gen;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic        HSYNC, VSYNC, DE;
  logic [10:0] X;
  logic [9:0]  Y;
  logic        LINE_START, FRAME_START, LINE_REQ;
  logic [9:0]  LINE_REQ_Y;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hs, vs, de, ls, fs, lr;
    logic [9:0]  lry;
  } obs_t;

  obs_t exp_q[$];

  always #5 CLK = ~CLK;

  video_timing_gen #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .DE(DE),
    .X(X), .Y(Y),
    .LINE_START(LINE_START), .FRAME_START(FRAME_START),
    .LINE_REQ(LINE_REQ), .LINE_REQ_Y(LINE_REQ_Y)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_x"}, int'(X), 0);
    chk({tag, "_y"}, int'(Y), 0);
    chk({tag, "_de"}, int'(DE), 0);
    chk({tag, "_ls"}, int'(LINE_START), 0);
    chk({tag, "_fs"}, int'(FRAME_START), 0);
    chk({tag, "_lr"}, int'(LINE_REQ), 0);
    chk({tag, "_lry"}, int'(LINE_REQ_Y), 0);
    chk({tag, "_hs"}, int'(HSYNC), 1);
    chk({tag, "_vs"}, int'(VSYNC), 1);
  endtask

  task automatic check_start(input string tag);
    chk({tag, "_x"}, int'(X), 0);
    chk({tag, "_y"}, int'(Y), 0);
    chk({tag, "_de"}, int'(DE), 1);
    chk({tag, "_ls"}, int'(LINE_START), 1);
    chk({tag, "_fs"}, int'(FRAME_START), 1);
    chk({tag, "_hs"}, int'(HSYNC), 1);
    chk({tag, "_vs"}, int'(VSYNC), 1);
  endtask

  // Reference raster: pushes one expected observation per clock edge.
  initial begin : model
    bit      run = 0;
    int      mx = 0, my = 0, lry = 0, yn;
    obs_t    e;
    forever begin
      @(posedge CLK);
      if (!RESET || !ENABLE) begin
        run = 0; mx = 0; my = 0; lry = 0;
      end else if (!run) begin
        run = 1; mx = 0; my = 0;
      end else if (mx == 31) begin
        mx = 0;
        my = (my == 19) ? 0 : my + 1;
      end else begin
        mx++;
      end
      yn    = (my == 19) ? 0 : my + 1;
      e.x   = 11'(mx);
      e.y   = 10'(my);
      e.hs  = !(run && mx >= 20 && mx <= 25);
      e.vs  = !(run && my >= 14 && my <= 16);
      e.de  = run && mx < 16 && my < 12;
      e.ls  = run && mx == 0;
      e.fs  = run && mx == 0 && my == 0;
      e.lr  = run && mx == 24 && yn < 12;
      if (e.lr) lry = yn;
      e.lry = 10'(lry);
      exp_q.push_back(e);
    end
  end

  always @(negedge CLK) begin : monitor
    obs_t a, e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {X, Y, HSYNC, VSYNC, DE, LINE_START, FRAME_START,
           LINE_REQ, LINE_REQ_Y};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL scoreboard t=%0t got %h want %h", $time, a, e);
      end
    end
  end

  initial begin : stim
    int de_line = 0, hs_line = 0;
    int de_f = 0, de_bad = 0, hs_f = 0, hs_bad = 0;
    int vs_f = 0, vs_bad = 0, ls_f = 0, ls_bad = 0, fs_f = 0;
    int lr_f = 0, lr_badx = 0, lr_gap = 0;
    int lry0 = -1, lry10 = -1, lry19 = -1;
    bit found;
    int c;

    RESET = 1'b0;
    ENABLE = 1'b0;
    repeat (3) @(negedge CLK);
    check_idle("reset");
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    check_idle("idle_dis");

    ENABLE = 1'b1;
    @(negedge CLK);
    check_start("first_run");

    // One full frame sampled from X=0,Y=0
    for (c = 0; c < 640; c++) begin
      if (c < 32) begin
        de_line += int'(DE);
        hs_line += int'(!HSYNC);
      end
      de_f += int'(DE);
      if (DE && Y >= 12) de_bad++;
      if (!HSYNC) begin
        hs_f++;
        if (X < 20 || X > 25) hs_bad++;
      end
      if (!VSYNC) begin
        vs_f++;
        if (Y < 14 || Y > 16) vs_bad++;
      end
      if (LINE_START) begin
        ls_f++;
        if (c % 32 != 0) ls_bad++;
      end
      fs_f += int'(FRAME_START);
      if (LINE_REQ) begin
        lr_f++;
        if (X != 24) lr_badx++;
        if (Y >= 11 && Y <= 18) lr_gap++;
        if (Y == 0)  lry0  = int'(LINE_REQ_Y);
        if (Y == 10) lry10 = int'(LINE_REQ_Y);
        if (Y == 19) lry19 = int'(LINE_REQ_Y);
      end
      if (c < 639) @(negedge CLK);
    end
    chk("line_de_cnt", de_line, 16);
    chk("line_hs_cnt", hs_line, 6);
    chk("frame_de_cnt", de_f, 192);
    chk("de_below_active", de_bad, 0);
    chk("frame_hs_cnt", hs_f, 120);
    chk("hs_outside_sync", hs_bad, 0);
    chk("frame_vs_cnt", vs_f, 96);
    chk("vs_outside_sync", vs_bad, 0);
    chk("ls_cnt", ls_f, 20);
    chk("ls_period", ls_bad, 0);
    chk("fs_cnt", fs_f, 1);
    chk("lr_cnt", lr_f, 12);
    chk("lr_x", lr_badx, 0);
    chk("lr_gap", lr_gap, 0);
    chk("lry_y0", lry0, 1);
    chk("lry_y10", lry10, 11);
    chk("lry_y19", lry19, 0);
    @(negedge CLK);
    chk("fs_period", int'(FRAME_START), 1);
    chk("fs_period_x", int'(X), 0);

    // Drop ENABLE at X=10, Y=5
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge CLK);
      if (X == 10 && Y == 5) found = 1;
    end
    chk("find_pos", int'(found), 1);
    chk("lry_hold", int'(LINE_REQ_Y), 5);
    ENABLE = 1'b0;
    @(negedge CLK);
    check_idle("shutdown");
    ENABLE = 1'b1;
    @(negedge CLK);
    check_start("restart");

    // Asynchronous reset between edges
    repeat (100) @(negedge CLK);
    #1 RESET = 1'b0;
    #1 check_idle("async_rst");
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_start("post_rst");

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_err++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
